mem_bus_arbiter: RTL and testbench



---
 rtl/mem_bus_arbiter_pkg.sv | 25 ++
 rtl/arb_watchdog.sv | 32 +++
 rtl/mem_bus_arbiter.sv | 216 +++++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared encodings and defaults for the fetch/data memory bus arbiter.
// Bus-side widths default to the 64-bit core datapath; fetch returns one 32-bit word.
package mem_bus_arbiter_pkg;

   localparam int unsigned ADDR_W_DFLT       = 64;
   localparam int unsigned DATA_W_DFLT       = 64;
   localparam int unsigned WMASK_W           = 8;
   localparam int unsigned IF_DATA_W         = 32;
   localparam int unsigned STARVE_LIMIT_DFLT = 4;
   localparam int unsigned TIMEOUT_DFLT      = 255;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_RESP = 2'd2,
      ST_DONE = 2'd3
   } arb_state_t;

   typedef enum logic [1:0] {
      OWN_NONE  = 2'd0,
      OWN_FETCH = 2'd1,
      OWN_DATA  = 2'd2
   } arb_owner_t;

endpackage

// File: rtl/arb_watchdog.sv
// Bus transaction watchdog: reloads while cleared, counts down while enabled and
// flags expiry on the TIMEOUT-th enabled cycle since the last clear.
module arb_watchdog
   import mem_bus_arbiter_pkg::*;
#(
   parameter int unsigned TIMEOUT = TIMEOUT_DFLT
)(
   input  logic sys_clk,
   input  logic sys_rst,
   input  logic clear,
   input  logic enable,
   output logic expire
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge sys_clk or negedge sys_rst) begin
      if (!sys_rst) begin
         cnt_q <= '0;
      end else if (clear) begin
         cnt_q <= CNT_W'(TIMEOUT);
      end else if (enable && (cnt_q != '0)) begin
         cnt_q <= cnt_q - CNT_W'(1);
      end
   end

   // Terminal count: the cycle holding 1 is the last one the transaction is allowed.
   assign expire = enable && (cnt_q == CNT_W'(1));

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one external memory bus between the fetch port and the data port,
// sequencing request/grant/response and producing per-port stalls.
//
//   state | meaning
//   IDLE  | arbitrate; latch winner's address/data/mask into bus_* registers
//   ADDR  | bus_req high, bus_* stable, waiting for bus_gnt
//   RESP  | address accepted, waiting for bus_rvalid
//   DONE  | one-cycle rvalid pulse to the owner (suppressed for a flushed fetch)
module mem_bus_arbiter
   import mem_bus_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W       = ADDR_W_DFLT,
   parameter int unsigned DATA_W       = DATA_W_DFLT,
   parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DFLT,
   parameter int unsigned TIMEOUT      = TIMEOUT_DFLT
)(
   input  logic                 sys_clk,
   input  logic                 sys_rst,

   input  logic                 if_req,
   input  logic [ADDR_W-1:0]    if_addr,
   input  logic                 if_flush,
   output logic [IF_DATA_W-1:0] if_rdata,
   output logic                 if_rvalid,
   output logic                 if_stall,

   input  logic                 d_req,
   input  logic                 d_we,
   input  logic [ADDR_W-1:0]    d_addr,
   input  logic [DATA_W-1:0]    d_wdata,
   input  logic [WMASK_W-1:0]   d_wmask,
   output logic [DATA_W-1:0]    d_rdata,
   output logic                 d_rvalid,
   output logic                 d_stall,

   output logic                 bus_req,
   output logic                 bus_we,
   output logic [ADDR_W-1:0]    bus_addr,
   output logic [DATA_W-1:0]    bus_wdata,
   output logic [WMASK_W-1:0]   bus_wmask,
   input  logic                 bus_gnt,
   input  logic                 bus_rvalid,
   input  logic [DATA_W-1:0]    bus_rdata,
   output logic                 bus_err
);

   localparam int unsigned SC_W = $clog2(STARVE_LIMIT + 1);

   arb_state_t       state_q;
   arb_state_t       state_d;
   arb_owner_t       owner_q;
   logic [SC_W-1:0]  starve_q;
   logic             drop_q;

   logic             in_idle;
   logic             in_addr;
   logic             in_resp;
   logic             in_done;
   logic             starve_full;
   logic             grant_fetch;
   logic             grant_data;
   logic             resp_take;
   logic             wd_clear;
   logic             wd_enable;
   logic             wd_expire;
   logic             timeout_hit;

   assign in_idle     = (state_q == ST_IDLE);
   assign in_addr     = (state_q == ST_ADDR);
   assign in_resp     = (state_q == ST_RESP);
   assign in_done     = (state_q == ST_DONE);
   assign starve_full = (starve_q == SC_W'(STARVE_LIMIT));

   assign wd_clear  = in_idle;
   assign wd_enable = in_addr || in_resp;

   arb_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .sys_clk (sys_clk),
      .sys_rst (sys_rst),
      .clear   (wd_clear),
      .enable  (wd_enable),
      .expire  (wd_expire)
   );

   // Data normally wins (older instruction); a starved fetch is forced through.
   always_comb begin
      grant_fetch = 1'b0;
      grant_data  = 1'b0;
      if (in_idle) begin
         if (if_req && starve_full) begin
            grant_fetch = 1'b1;
         end else if (d_req) begin
            grant_data = 1'b1;
         end else if (if_req) begin
            grant_fetch = 1'b1;
         end
      end
   end

   // A response in the same cycle as the grant counts; a real response beats expiry.
   assign resp_take   = (in_resp && bus_rvalid) || (in_addr && bus_gnt && bus_rvalid);
   assign timeout_hit = wd_expire && !resp_take;

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (grant_fetch || grant_data) begin
               state_d = ST_ADDR;
            end
         end
         ST_ADDR: begin
            if (resp_take || timeout_hit) begin
               state_d = ST_DONE;
            end else if (bus_gnt) begin
               state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            if (resp_take || timeout_hit) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge sys_clk or negedge sys_rst) begin
      if (!sys_rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst) begin
      if (!sys_rst) begin
         owner_q   <= OWN_NONE;
         bus_we    <= 1'b0;
         bus_addr  <= '0;
         bus_wdata <= '0;
         bus_wmask <= '0;
      end else if (grant_fetch) begin
         owner_q   <= OWN_FETCH;
         bus_we    <= 1'b0;
         bus_addr  <= if_addr;
         bus_wdata <= '0;
         bus_wmask <= '0;
      end else if (grant_data) begin
         owner_q   <= OWN_DATA;
         bus_we    <= d_we;
         bus_addr  <= d_addr;
         bus_wdata <= d_wdata;
         bus_wmask <= d_wmask;
      end else if (in_done) begin
         owner_q   <= OWN_NONE;
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst) begin
      if (!sys_rst) begin
         starve_q <= '0;
      end else if (grant_fetch) begin
         starve_q <= '0;
      end else if (grant_data && if_req && !starve_full) begin
         starve_q <= starve_q + SC_W'(1);
      end
   end

   // A redirect while our fetch is on the bus lets it finish but hides the result.
   always_ff @(posedge sys_clk or negedge sys_rst) begin
      if (!sys_rst) begin
         drop_q <= 1'b0;
      end else if (in_done) begin
         drop_q <= 1'b0;
      end else if ((in_addr || in_resp) && (owner_q == OWN_FETCH) && if_flush) begin
         drop_q <= 1'b1;
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst) begin
      if (!sys_rst) begin
         if_rdata <= '0;
         d_rdata  <= '0;
         bus_err  <= 1'b0;
      end else if (resp_take) begin
         if (owner_q == OWN_FETCH) begin
            if_rdata <= bus_addr[2] ? bus_rdata[2*IF_DATA_W-1:IF_DATA_W]
                                    : bus_rdata[IF_DATA_W-1:0];
         end else if (owner_q == OWN_DATA) begin
            d_rdata <= bus_rdata;
         end
      end else if (timeout_hit) begin
         bus_err <= 1'b1;
         if (owner_q == OWN_FETCH) begin
            if_rdata <= '0;
         end else if (owner_q == OWN_DATA) begin
            d_rdata <= '0;
         end
      end
   end

   assign bus_req   = in_addr;
   assign if_rvalid = in_done && (owner_q == OWN_FETCH) && !drop_q;
   assign d_rvalid  = in_done && (owner_q == OWN_DATA);
   assign if_stall  = if_req && !if_rvalid;
   assign d_stall   = d_req && !d_rvalid;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: per-cycle vector table for single
// transactions, then hand sequences for starvation, flush, timeout and reset.
module tb_mem_bus_arbiter;

   localparam logic        O   = 1'b0;
   localparam logic        I   = 1'b1;
   localparam logic [63:0] Z   = 64'd0;
   localparam logic [31:0] Z32 = 32'd0;
   localparam logic [7:0]  Z8  = 8'd0;
   localparam logic [63:0] FA  = 64'h0000_0000_8000_0004;
   localparam logic [63:0] R1  = 64'h1111_2222_3333_4444;
   localparam logic [63:0] FB  = 64'h0000_0000_0000_2000;
   localparam logic [63:0] DA  = 64'h0000_0000_0000_1000;
   localparam logic [63:0] RD  = 64'hAAAA_BBBB_CCCC_DDDD;
   localparam logic [63:0] RF  = 64'h0123_4567_89AB_CDEF;
   localparam logic [63:0] SA  = 64'h0000_0000_0000_3008;
   localparam logic [63:0] SW  = 64'hDEAD_BEEF_0000_5555;
   localparam int          NV  = 19;

   logic        sys_clk;
   logic        sys_rst;
   logic        if_req;
   logic [63:0] if_addr;
   logic        if_flush;
   logic [31:0] if_rdata;
   logic        if_rvalid;
   logic        if_stall;
   logic        d_req;
   logic        d_we;
   logic [63:0] d_addr;
   logic [63:0] d_wdata;
   logic [7:0]  d_wmask;
   logic [63:0] d_rdata;
   logic        d_rvalid;
   logic        d_stall;
   logic        bus_req;
   logic        bus_we;
   logic [63:0] bus_addr;
   logic [63:0] bus_wdata;
   logic [7:0]  bus_wmask;
   logic        bus_gnt;
   logic        bus_rvalid;
   logic [63:0] bus_rdata;
   logic        bus_err;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        if_req;
      logic [63:0] if_addr;
      logic        d_req;
      logic        d_we;
      logic [63:0] d_addr;
      logic [63:0] d_wdata;
      logic [7:0]  d_wmask;
      logic        gnt;
      logic        rv;
      logic [63:0] rdata;
      logic        e_req;
      logic [63:0] e_addr;
      logic        e_we;
      logic [63:0] e_wdata;
      logic [7:0]  e_wmask;
      logic        e_if_rv;
      logic [31:0] e_if_rdata;
      logic        e_d_rv;
      logic [63:0] e_d_rdata;
      logic        e_if_stall;
      logic        e_d_stall;
   } vec_t;

   vec_t        vecs [NV];
   logic [63:0] st_exp [7];

   mem_bus_arbiter #(
      .ADDR_W       (64),
      .DATA_W       (64),
      .STARVE_LIMIT (4),
      .TIMEOUT      (8)
   ) dut (
      .sys_clk    (sys_clk),
      .sys_rst    (sys_rst),
      .if_req     (if_req),
      .if_addr    (if_addr),
      .if_flush   (if_flush),
      .if_rdata   (if_rdata),
      .if_rvalid  (if_rvalid),
      .if_stall   (if_stall),
      .d_req      (d_req),
      .d_we       (d_we),
      .d_addr     (d_addr),
      .d_wdata    (d_wdata),
      .d_wmask    (d_wmask),
      .d_rdata    (d_rdata),
      .d_rvalid   (d_rvalid),
      .d_stall    (d_stall),
      .bus_req    (bus_req),
      .bus_we     (bus_we),
      .bus_addr   (bus_addr),
      .bus_wdata  (bus_wdata),
      .bus_wmask  (bus_wmask),
      .bus_gnt    (bus_gnt),
      .bus_rvalid (bus_rvalid),
      .bus_rdata  (bus_rdata),
      .bus_err    (bus_err)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   initial begin
      #100000;
      $display("FAIL global_timeout: simulation still running at %0t, required finish", $time);
      $fatal(1, "bench did not finish");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic wait_bus_req();
      int n = 0;
      do begin
         @(negedge sys_clk);
         #1;
         n++;
      end while (bus_req !== 1'b1 && n < 20);
      check("bus_req_seen", 64'(bus_req), 64'd1);
   endtask

   initial begin
      vecs[0]  = '{I,FA, O,O,Z,Z,Z8,  O,O,Z,  O,Z,O,Z,Z8,  O,Z32,  O,Z, I,O};
      vecs[1]  = '{I,FA, O,O,Z,Z,Z8,  I,O,Z,  I,FA,O,Z,Z8, O,Z32,  O,Z, I,O};
      vecs[2]  = '{I,FA, O,O,Z,Z,Z8,  O,O,Z,  O,Z,O,Z,Z8,  O,Z32,  O,Z, I,O};
      vecs[3]  = '{I,FA, O,O,Z,Z,Z8,  O,I,R1, O,Z,O,Z,Z8,  O,Z32,  O,Z, I,O};
      vecs[4]  = '{I,FA, O,O,Z,Z,Z8,  O,O,Z,  O,Z,O,Z,Z8,  I,32'h1111_2222, O,Z, O,O};
      vecs[5]  = '{O,Z,  O,O,Z,Z,Z8,  O,O,Z,  O,Z,O,Z,Z8,  O,Z32,  O,Z, O,O};
      vecs[6]  = '{I,FB, I,O,DA,Z,Z8, O,O,Z,  O,Z,O,Z,Z8,  O,Z32,  O,Z, I,I};
      vecs[7]  = '{I,FB, I,O,DA,Z,Z8, I,O,Z,  I,DA,O,Z,Z8, O,Z32,  O,Z, I,I};
      vecs[8]  = '{I,FB, I,O,DA,Z,Z8, O,I,RD, O,Z,O,Z,Z8,  O,Z32,  O,Z, I,I};
      vecs[9]  = '{I,FB, I,O,DA,Z,Z8, O,O,Z,  O,Z,O,Z,Z8,  O,Z32,  I,RD, I,O};
      vecs[10] = '{I,FB, O,O,Z,Z,Z8,  O,O,Z,  O,Z,O,Z,Z8,  O,Z32,  O,Z, I,O};
      vecs[11] = '{I,FB, O,O,Z,Z,Z8,  I,I,RF, I,FB,O,Z,Z8, O,Z32,  O,Z, I,O};
      vecs[12] = '{I,FB, O,O,Z,Z,Z8,  O,O,Z,  O,Z,O,Z,Z8,  I,32'h89AB_CDEF, O,Z, O,O};
      vecs[13] = '{O,Z,  O,O,Z,Z,Z8,  O,O,Z,  O,Z,O,Z,Z8,  O,Z32,  O,Z, O,O};
      vecs[14] = '{O,Z,  I,I,SA,SW,8'hF0, O,O,Z,  O,Z,O,Z,Z8,         O,Z32, O,Z, O,I};
      vecs[15] = '{O,Z,  I,I,SA,SW,8'hF0, I,O,Z,  I,SA,I,SW,8'hF0,   O,Z32, O,Z, O,I};
      vecs[16] = '{O,Z,  I,I,SA,SW,8'hF0, O,I,64'h5A5A, O,Z,O,Z,Z8,  O,Z32, O,Z, O,I};
      vecs[17] = '{O,Z,  I,I,SA,SW,8'hF0, O,O,Z,  O,Z,O,Z,Z8,         O,Z32, I,Z, O,O};
      vecs[18] = '{O,Z,  O,O,Z,Z,Z8,  O,O,Z,  O,Z,O,Z,Z8,  O,Z32,  O,Z, O,O};

      st_exp[0] = 64'h100;
      st_exp[1] = 64'h108;
      st_exp[2] = 64'h110;
      st_exp[3] = 64'h118;
      st_exp[4] = 64'h4000;
      st_exp[5] = 64'h120;
      st_exp[6] = 64'h128;

      sys_rst    = 1'b0;
      if_req     = 1'b0;
      if_addr    = '0;
      if_flush   = 1'b0;
      d_req      = 1'b0;
      d_we       = 1'b0;
      d_addr     = '0;
      d_wdata    = '0;
      d_wmask    = '0;
      bus_gnt    = 1'b0;
      bus_rvalid = 1'b0;
      bus_rdata  = '0;

      // reset state
      repeat (2) @(negedge sys_clk);
      #1;
      check("rst bus_req",   64'(bus_req),   64'd0);
      check("rst bus_we",    64'(bus_we),    64'd0);
      check("rst bus_err",   64'(bus_err),   64'd0);
      check("rst if_rvalid", 64'(if_rvalid), 64'd0);
      check("rst d_rvalid",  64'(d_rvalid),  64'd0);
      check("rst bus_addr",  bus_addr,       64'd0);
      check("rst bus_wdata", bus_wdata,      64'd0);
      check("rst bus_wmask", 64'(bus_wmask), 64'd0);
      check("rst if_rdata",  64'(if_rdata),  64'd0);
      check("rst d_rdata",   d_rdata,        64'd0);
      @(negedge sys_clk);
      sys_rst = 1'b1;

      // table: lone fetch, contention with same-cycle gnt+rvalid, store
      for (int i = 0; i < NV; i++) begin
         @(negedge sys_clk);
         if_req     = vecs[i].if_req;
         if_addr    = vecs[i].if_addr;
         d_req      = vecs[i].d_req;
         d_we       = vecs[i].d_we;
         d_addr     = vecs[i].d_addr;
         d_wdata    = vecs[i].d_wdata;
         d_wmask    = vecs[i].d_wmask;
         bus_gnt    = vecs[i].gnt;
         bus_rvalid = vecs[i].rv;
         bus_rdata  = vecs[i].rdata;
         #1;
         check($sformatf("vec%0d bus_req", i),   64'(bus_req),   64'(vecs[i].e_req));
         check($sformatf("vec%0d if_rvalid", i), 64'(if_rvalid), 64'(vecs[i].e_if_rv));
         check($sformatf("vec%0d d_rvalid", i),  64'(d_rvalid),  64'(vecs[i].e_d_rv));
         check($sformatf("vec%0d if_stall", i),  64'(if_stall),  64'(vecs[i].e_if_stall));
         check($sformatf("vec%0d d_stall", i),   64'(d_stall),   64'(vecs[i].e_d_stall));
         if (vecs[i].e_req) begin
            check($sformatf("vec%0d bus_addr", i), bus_addr,     vecs[i].e_addr);
            check($sformatf("vec%0d bus_we", i),   64'(bus_we),  64'(vecs[i].e_we));
            if (vecs[i].e_we) begin
               check($sformatf("vec%0d bus_wdata", i), bus_wdata,       vecs[i].e_wdata);
               check($sformatf("vec%0d bus_wmask", i), 64'(bus_wmask),  64'(vecs[i].e_wmask));
            end
         end
         if (vecs[i].e_if_rv) begin
            check($sformatf("vec%0d if_rdata", i), 64'(if_rdata), 64'(vecs[i].e_if_rdata));
         end
         if (vecs[i].e_d_rv && !vecs[i].d_we) begin
            check($sformatf("vec%0d d_rdata", i), d_rdata, vecs[i].e_d_rdata);
         end
      end
      check("bus_err after table", 64'(bus_err), 64'd0);

      // starvation: fetch held, data back-to-back; 5th grant must be the fetch
      if_req = 1'b1;
      if_addr = 64'h4000;
      d_req  = 1'b1;
      d_we   = 1'b0;
      d_addr = 64'h100;
      for (int g = 0; g < 7; g++) begin
         wait_bus_req();
         check($sformatf("starve grant%0d addr", g), bus_addr, st_exp[g]);
         bus_gnt = 1'b1;
         @(negedge sys_clk);
         bus_gnt    = 1'b0;
         bus_rvalid = 1'b1;
         bus_rdata  = 64'hC0FF_EE00 + 64'(g);
         @(negedge sys_clk);
         bus_rvalid = 1'b0;
         #1;
         check($sformatf("starve grant%0d d_rvalid", g),  64'(d_rvalid),  (g == 4) ? 64'd0 : 64'd1);
         check($sformatf("starve grant%0d if_rvalid", g), 64'(if_rvalid), (g == 4) ? 64'd1 : 64'd0);
         if (g != 4) d_addr = d_addr + 64'd8;
      end
      d_req = 1'b0;

      // flush during RESP of a fetch, then redirected fetch issues normally
      if_req  = 1'b1;
      if_addr = 64'h5004;
      wait_bus_req();
      check("flush first addr", bus_addr, 64'h5004);
      bus_gnt = 1'b1;
      @(negedge sys_clk);
      bus_gnt  = 1'b0;
      if_flush = 1'b1;
      if_addr  = 64'h6000;
      #1;
      check("flush in RESP bus_req", 64'(bus_req), 64'd0);
      @(negedge sys_clk);
      if_flush   = 1'b0;
      bus_rvalid = 1'b1;
      bus_rdata  = 64'h7777_8888_9999_AAAA;
      @(negedge sys_clk);
      bus_rvalid = 1'b0;
      #1;
      check("flush suppressed if_rvalid", 64'(if_rvalid), 64'd0);
      check("flush if_stall held",        64'(if_stall),  64'd1);
      @(negedge sys_clk);
      #1;
      check("flush back to idle bus_req", 64'(bus_req), 64'd0);
      wait_bus_req();
      check("flush refetch addr", bus_addr, 64'h6000);
      bus_gnt    = 1'b1;
      bus_rvalid = 1'b1;
      bus_rdata  = 64'hBBBB_CCCC_DDDD_EEEE;
      @(negedge sys_clk);
      bus_gnt    = 1'b0;
      bus_rvalid = 1'b0;
      #1;
      check("refetch if_rvalid", 64'(if_rvalid), 64'd1);
      check("refetch if_rdata",  64'(if_rdata),  64'h0000_0000_DDDD_EEEE);
      if_req = 1'b0;

      // timeout: no grant ever, TIMEOUT=8
      d_req  = 1'b1;
      d_we   = 1'b0;
      d_addr = 64'h7000;
      check("bus_err before timeout", 64'(bus_err), 64'd0);
      wait_bus_req();
      begin
         int n = 0;
         while (bus_req === 1'b1 && n < 40) begin
            n++;
            @(negedge sys_clk);
            #1;
         end
         check("timeout bus_req cycles", 64'(n), 64'd8);
      end
      check("timeout d_rvalid", 64'(d_rvalid), 64'd1);
      check("timeout d_rdata",  d_rdata,       64'd0);
      check("timeout bus_err",  64'(bus_err),  64'd1);
      d_req = 1'b0;
      repeat (3) @(negedge sys_clk);
      #1;
      check("bus_err sticky", 64'(bus_err), 64'd1);

      // asynchronous reset in the middle of RESP; late response ignored
      if_req  = 1'b1;
      if_addr = 64'h8000;
      wait_bus_req();
      bus_gnt = 1'b1;
      @(negedge sys_clk);
      bus_gnt = 1'b0;
      #2;
      sys_rst = 1'b0;
      if_req  = 1'b0;
      #1;
      check("async rst bus_addr",  bus_addr,       64'd0);
      check("async rst bus_req",   64'(bus_req),   64'd0);
      check("async rst bus_err",   64'(bus_err),   64'd0);
      check("async rst if_rvalid", 64'(if_rvalid), 64'd0);
      @(negedge sys_clk);
      sys_rst = 1'b1;
      @(negedge sys_clk);
      bus_rvalid = 1'b1;
      bus_rdata  = 64'h1234_5678_9ABC_DEF0;
      #1;
      check("late rvalid bus_req", 64'(bus_req), 64'd0);
      @(negedge sys_clk);
      bus_rvalid = 1'b0;
      #1;
      check("late rvalid if_rvalid", 64'(if_rvalid), 64'd0);
      check("late rvalid d_rvalid",  64'(d_rvalid),  64'd0);
      check("late rvalid if_rdata",  64'(if_rdata),  64'd0);

      // post-reset fetch from the upper word
      if_req  = 1'b1;
      if_addr = 64'h9004;
      wait_bus_req();
      check("post rst addr", bus_addr, 64'h9004);
      bus_gnt    = 1'b1;
      bus_rvalid = 1'b1;
      bus_rdata  = 64'hFEED_FACE_1234_5678;
      @(negedge sys_clk);
      bus_gnt    = 1'b0;
      bus_rvalid = 1'b0;
      #1;
      check("post rst if_rvalid", 64'(if_rvalid), 64'd1);
      check("post rst if_rdata",  64'(if_rdata),  64'h0000_0000_FEED_FACE);
      if_req = 1'b0;
      @(negedge sys_clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
